// File: rtl/helai_video_pkg.sv
// ---------------------------------------------------------------------------
// helai_video_pkg : shared state encoding and size defaults for the video path
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package helai_video_pkg;

   localparam int c_DSIZE_DEFAULT = 24;
   localparam int c_CSIZE_DEFAULT = 12;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_t;

endpackage

`default_nettype wire

// File: rtl/helai_fifo2axis_if.sv
// ---------------------------------------------------------------------------
// helai_fifo2axis_if : FIFO read side plus AXI4-Stream video master bundle
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface helai_fifo2axis_if #(
   parameter int DSIZE = 24
);
   logic [DSIZE-1:0] fifo_rdata;
   logic             fifo_rempty;
   logic             fifo_rinc;
   logic [DSIZE-1:0] m_axis_tdata;
   logic             m_axis_tvalid;
   logic             m_axis_tready;
   logic             m_axis_tuser;
   logic             m_axis_tlast;

   modport master (
      input  fifo_rdata, fifo_rempty, m_axis_tready,
      output fifo_rinc, m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast
   );

   modport slave (
      output fifo_rdata, fifo_rempty, m_axis_tready,
      input  fifo_rinc, m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast
   );
endinterface

`default_nettype wire

// File: rtl/helai_axis_outreg.sv
// ---------------------------------------------------------------------------
// helai_axis_outreg : single-entry AXI-Stream output register (data/user/last)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module helai_axis_outreg #(
   parameter int DSIZE = 24
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             i_load,
   input  wire logic [DSIZE-1:0] i_data,
   input  wire logic             i_user,
   input  wire logic             i_last,
   input  wire logic             i_ready,
   output logic      [DSIZE-1:0] o_data,
   output logic                  o_valid,
   output logic                  o_user,
   output logic                  o_last
);

   logic [DSIZE-1:0] r_data;
   logic             r_valid;
   logic             r_user;
   logic             r_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_user  <= 1'b0;
         r_last  <= 1'b0;
      end else if (i_load) begin
         r_data  <= i_data;
         r_user  <= i_user;
         r_last  <= i_last;
         r_valid <= 1'b1;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;
   assign o_user  = r_user;
   assign o_last  = r_last;

endmodule

`default_nettype wire

// File: rtl/helai_fifo2axis.sv
// ---------------------------------------------------------------------------
// helai_fifo2axis : streams FWFT FIFO pixels as AXI4-Stream video frames
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module helai_fifo2axis
   import helai_video_pkg::*;
#(
   parameter int DSIZE = c_DSIZE_DEFAULT,
   parameter int CSIZE = c_CSIZE_DEFAULT
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             enable,
   input  wire logic [CSIZE-1:0] h_active,
   input  wire logic [CSIZE-1:0] v_active,
   output logic                  frame_busy,
   output logic                  underflow,
   helai_fifo2axis_if.master     bus
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CSIZE-1:0] r_x;
   logic [CSIZE-1:0] r_y;
   logic [CSIZE-1:0] r_h;
   logic [CSIZE-1:0] r_v;
   logic             r_underflow;

   logic             w_start;
   logic             w_slot_free;
   logic             w_load;
   logic             w_x_last;
   logic             w_y_last;
   logic             w_frame_end;
   logic [DSIZE-1:0] w_tdata;
   logic             w_tvalid;
   logic             w_tuser;
   logic             w_tlast;

   assign w_start     = enable && (h_active != '0) && (v_active != '0);
   assign w_slot_free = !w_tvalid || bus.m_axis_tready;
   assign w_load      = !rst && (r_state == ST_STREAM) && !bus.fifo_rempty && w_slot_free;
   assign w_x_last    = (r_x == r_h - CSIZE'(1));
   assign w_y_last    = (r_y == r_v - CSIZE'(1));
   assign w_frame_end = w_load && w_x_last && w_y_last;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (w_start) w_state_nxt = ST_STREAM;
         // Back-to-back frames only when the next frame has a usable size.
         ST_STREAM: if (w_frame_end && !w_start) w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_x         <= '0;
         r_y         <= '0;
         r_h         <= '0;
         r_v         <= '0;
         r_underflow <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == ST_IDLE) && w_start) begin
            r_h <= h_active;
            r_v <= v_active;
            r_x <= '0;
            r_y <= '0;
         end else if (w_load) begin
            if (w_x_last) begin
               r_x <= '0;
               if (w_y_last) begin
                  r_y <= '0;
                  if (w_start) begin
                     r_h <= h_active;
                     r_v <= v_active;
                  end
               end else begin
                  r_y <= r_y + CSIZE'(1);
               end
            end else begin
               r_x <= r_x + CSIZE'(1);
            end
         end
         // Starvation only counts inside a line; waiting at x=0 is a legal gap.
         if ((r_state == ST_STREAM) && (r_x != '0) && bus.fifo_rempty && w_slot_free)
            r_underflow <= 1'b1;
      end
   end

   helai_axis_outreg #(
      .DSIZE (DSIZE)
   ) u_outreg (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load),
      .i_data  (bus.fifo_rdata),
      .i_user  ((r_x == '0) && (r_y == '0)),
      .i_last  (w_x_last),
      .i_ready (bus.m_axis_tready),
      .o_data  (w_tdata),
      .o_valid (w_tvalid),
      .o_user  (w_tuser),
      .o_last  (w_tlast)
   );

   assign bus.fifo_rinc     = w_load;
   assign bus.m_axis_tdata  = w_tdata;
   assign bus.m_axis_tvalid = w_tvalid;
   assign bus.m_axis_tuser  = w_tuser;
   assign bus.m_axis_tlast  = w_tlast;
   assign frame_busy        = !rst && (r_state == ST_STREAM);
   assign underflow         = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_helai_fifo2axis.sv
// ---------------------------------------------------------------------------
// tb_helai_fifo2axis : frame-level scoreboard bench for helai_fifo2axis
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_helai_fifo2axis;

   localparam int DW = 24;
   localparam int CW = 12;

   typedef struct packed {
      int            cyc;
      logic [DW-1:0] data;
      logic          user;
      logic          last;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic [CW-1:0] h_active = '0;
   logic [CW-1:0] v_active = '0;
   logic          frame_busy;
   logic          underflow;

   helai_fifo2axis_if #(.DSIZE(DW)) bus ();

   helai_fifo2axis #(.DSIZE(DW), .CSIZE(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .h_active   (h_active),
      .v_active   (v_active),
      .frame_busy (frame_busy),
      .underflow  (underflow),
      .bus        (bus.master)
   );

   always #5 clk = ~clk;

   // FWFT FIFO model: head word is visible whenever non-empty
   logic [DW-1:0] mem [0:255];
   int            wr_ptr = 0;
   int            rd_ptr = 0;
   logic [DW-1:0] exp_q[$];

   assign bus.fifo_rempty = (wr_ptr == rd_ptr);
   assign bus.fifo_rdata  = mem[rd_ptr[7:0]];

   always @(posedge clk) if (bus.fifo_rinc && (wr_ptr != rd_ptr)) rd_ptr <= rd_ptr + 1;

   int   tready_mode = 0;
   logic tready_r    = 1'b1;
   assign bus.m_axis_tready = tready_r;

   always @(posedge clk) begin
      #1;
      case (tready_mode)
         0:       tready_r = 1'b1;
         1:       tready_r = ~tready_r;
         default: tready_r = 1'($urandom_range(0, 1));
      endcase
   end

   beat_t         got[$];
   int            cyc = 0;
   int            rinc_cnt = 0;
   int            rinc_empty = 0;
   int            stall_errs = 0;
   int            busy_low = 0;
   bit            watch_busy = 0;
   logic          prev_stall = 1'b0;
   logic [DW+1:0] prev_out = '0;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (bus.fifo_rinc) rinc_cnt = rinc_cnt + 1;
      if (bus.fifo_rinc && bus.fifo_rempty) rinc_empty = rinc_empty + 1;
      if (watch_busy && !frame_busy) busy_low = busy_low + 1;
      if (prev_stall && (!bus.m_axis_tvalid ||
          ({bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tlast} !== prev_out)))
         stall_errs = stall_errs + 1;
      prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready && !rst;
      prev_out   = {bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tlast};
      if (bus.m_axis_tvalid && bus.m_axis_tready)
         got.push_back('{cyc, bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tlast});
   end

   int checks = 0;
   int errors = 0;
   int got_rd = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_words(input int n);
      for (int i = 0; i < n; i++) begin
         logic [DW-1:0] w;
         w = DW'($urandom);
         mem[wr_ptr[7:0]] = w;
         exp_q.push_back(w);
         wr_ptr = wr_ptr + 1;
      end
   endtask

   task automatic pulse(input int h, input int v);
      h_active = CW'(h);
      v_active = CW'(v);
      enable   = 1'b1;
      tick(1);
      enable   = 1'b0;
   endtask

   task automatic wait_beats(input int n, input int budget, input string tag);
      int k;
      k = 0;
      while ((got.size() - got_rd < n) && (k < budget)) begin
         @(negedge clk);
         #1;
         k++;
      end
      chk(tag, 64'(got.size() - got_rd), 64'(n));
   endtask

   // Expected frame: pixels in FIFO order, SOF on the first, EOL every h-th
   task automatic expect_frame(input int h, input int v, input string tag);
      for (int k = 0; k < h * v; k++) begin
         beat_t         b;
         logic [DW-1:0] w;
         b = '0;
         w = '0;
         if (got_rd < got.size()) begin
            b = got[got_rd];
            got_rd++;
         end
         if (exp_q.size() > 0) w = exp_q.pop_front();
         chk($sformatf("%s_data%0d", tag, k), 64'(b.data), 64'(w));
         chk($sformatf("%s_user%0d", tag, k), 64'(b.user), 64'(k == 0));
         chk($sformatf("%s_last%0d", tag, k), 64'(b.last), 64'((k % h) == (h - 1)));
      end
   endtask

   initial begin
      #300000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int base;
      int rem;
      int gap;
      int h;
      int v;

      tick(3);
      chk("rst_tvalid", 64'(bus.m_axis_tvalid), 0);
      chk("rst_tdata", 64'(bus.m_axis_tdata), 0);
      chk("rst_tuser", 64'(bus.m_axis_tuser), 0);
      chk("rst_tlast", 64'(bus.m_axis_tlast), 0);
      chk("rst_rinc", 64'(bus.fifo_rinc), 0);
      chk("rst_busy", 64'(frame_busy), 0);
      chk("rst_underflow", 64'(underflow), 0);
      rst = 1'b0;
      tick(2);

      // 4x2 frame, tready always high
      base = rinc_cnt;
      push_words(8);
      pulse(4, 2);
      wait_beats(8, 60, "A_beats");
      tick(3);
      chk("A_rinc_cycles", 64'(rinc_cnt - base), 8);
      chk("A_idle", 64'(frame_busy), 0);
      expect_frame(4, 2, "A");

      // same frame with tready toggling
      tready_mode = 1;
      push_words(8);
      pulse(4, 2);
      wait_beats(8, 100, "B_beats");
      tick(3);
      expect_frame(4, 2, "B");
      chk("B_stall_stable", 64'(stall_errs), 0);
      tready_mode = 0;
      tick(2);

      // FIFO starves mid-line
      push_words(2);
      pulse(4, 1);
      tick(10);
      chk("C_underflow", 64'(underflow), 1);
      chk("C_tvalid_low", 64'(bus.m_axis_tvalid), 0);
      chk("C_partial", 64'(got.size() - got_rd), 2);
      push_words(2);
      wait_beats(4, 60, "C_beats");
      tick(3);
      expect_frame(4, 1, "C");
      chk("C_underflow_sticky", 64'(underflow), 1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("C_underflow_clr", 64'(underflow), 0);
      tick(2);

      // back-to-back 2x2 frames with enable held
      base = busy_low;
      push_words(8);
      h_active = 12'd2;
      v_active = 12'd2;
      enable   = 1'b1;
      wait_beats(1, 40, "D_first");
      watch_busy = 1;
      wait_beats(8, 60, "D_beats");
      watch_busy = 0;
      chk("D_busy_held", 64'(busy_low - base), 0);
      gap = -1;
      if (got.size() >= got_rd + 5) gap = got[got_rd + 4].cyc - got[got_rd + 3].cyc;
      chk("D_no_gap", 64'(gap), 1);
      expect_frame(2, 2, "D0");
      expect_frame(2, 2, "D1");
      enable = 1'b0;
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(2);

      // reset in the middle of a 4x2 frame
      push_words(8);
      pulse(4, 2);
      wait_beats(5, 60, "E_beats");
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("E_tvalid", 64'(bus.m_axis_tvalid), 0);
      chk("E_tdata", 64'(bus.m_axis_tdata), 0);
      chk("E_tuser", 64'(bus.m_axis_tuser), 0);
      chk("E_tlast", 64'(bus.m_axis_tlast), 0);
      chk("E_rinc", 64'(bus.fifo_rinc), 0);
      chk("E_busy", 64'(frame_busy), 0);
      got_rd = got.size();
      while (exp_q.size() > wr_ptr - rd_ptr) void'(exp_q.pop_front());
      rem = wr_ptr - rd_ptr;
      chk("E_rem_fits", 64'(rem <= 4), 1);
      if (rem < 4) push_words(4 - rem);
      pulse(4, 1);
      wait_beats(4, 60, "E2_beats");
      tick(3);
      expect_frame(4, 1, "E2");

      // zero width never starts; then single-pixel lines
      base = rinc_cnt;
      push_words(3);
      h_active = '0;
      v_active = 12'd3;
      enable   = 1'b1;
      tick(10);
      chk("F_no_rinc", 64'(rinc_cnt - base), 0);
      chk("F_idle", 64'(frame_busy), 0);
      enable = 1'b0;
      tick(1);
      pulse(1, 3);
      wait_beats(3, 60, "F_beats");
      tick(3);
      expect_frame(1, 3, "F");

      // randomized frame sizes with random backpressure
      tready_mode = 2;
      for (int i = 0; i < 4; i++) begin
         h = int'($urandom_range(1, 5));
         v = int'($urandom_range(1, 3));
         push_words(h * v);
         pulse(h, v);
         wait_beats(h * v, 400, $sformatf("G%0d_beats", i));
         tick(4);
         expect_frame(h, v, $sformatf("G%0d", i));
      end
      chk("G_stall_stable", 64'(stall_errs), 0);
      chk("rinc_while_empty", 64'(rinc_empty), 0);
      tready_mode = 0;
      tick(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/helai_fifo2axis.md
HELAI_FIFO2AXIS -- requirements
Module: helai_fifo2axis

Interface
REQ-001 SHALL have parameter DSIZE, default 24, pixel word width (matches the upstream FIFO DSIZE).
REQ-002 SHALL have parameter CSIZE, default 12, width of the line/pixel counters and size inputs.
REQ-003 SHALL have port clk  input  1  sole clock, equal to the upstream FIFO rclk; one clock only.
REQ-004 SHALL have port rst  input  1  reset, synchronous to clk, active-high.
REQ-005 SHALL have port enable  input  1  run request, sampled only at frame boundaries.
REQ-006 SHALL have port h_active  input  CSIZE  pixels per line.
REQ-007 SHALL have port v_active  input  CSIZE  lines per frame.
REQ-008 SHALL have port fifo_rdata  input  DSIZE  FIFO read data, first-word fall-through (valid whenever fifo_rempty is low).
REQ-009 SHALL have port fifo_rempty  input  1  FIFO empty.
REQ-010 SHALL have port fifo_rinc  output  1  FIFO read strobe, one word per high cycle.
REQ-011 SHALL have port m_axis_tdata  output  DSIZE  pixel out.
REQ-012 SHALL have port m_axis_tvalid  output  1  output valid.
REQ-013 SHALL have port m_axis_tready  input  1  downstream ready.
REQ-014 SHALL have port m_axis_tuser  output  1  start of frame, first pixel only.
REQ-015 SHALL have port m_axis_tlast  output  1  end of line, last pixel of each line.
REQ-016 SHALL have port frame_busy  output  1  high while in STREAM.
REQ-017 SHALL have port underflow  output  1  sticky mid-line starvation flag.

Function
REQ-018 SHALL implement states IDLE and STREAM.
REQ-019 IDLE->STREAM SHALL occur when enable=1, h_active!=0 and v_active!=0; otherwise it SHALL remain in IDLE.
REQ-020 On the IDLE->STREAM transition it SHALL latch h_active/v_active; mid-frame input changes SHALL be ignored.
REQ-021 The load condition SHALL be: state=STREAM and fifo_rempty=0 and (m_axis_tvalid=0 or m_axis_tready=1).
REQ-022 fifo_rinc SHALL equal the load condition combinationally; it SHALL never be high while fifo_rempty=1.
REQ-023 On load, the output register SHALL capture fifo_rdata; that word appears on m_axis_tdata one cycle after fifo_rinc.
REQ-024 m_axis_tvalid SHALL set on load, clear on (tvalid and tready and no load), and hold otherwise.
REQ-025 tdata/tuser/tlast SHALL remain stable while tvalid=1 and tready=0.
REQ-026 The x counter SHALL advance on each load; at x=h_active-1 it SHALL wrap to 0 and advance the y counter.
REQ-027 tuser SHALL be registered high for the word loaded at x=0,y=0; tlast SHALL be registered high for the word loaded at x=h_active-1.
REQ-028 On loading the last frame pixel (x=h_active-1, y=v_active-1), the y counter SHALL wrap to 0.
REQ-029 At that point, if enable=1, it SHALL stay in STREAM and re-latch the sizes (back-to-back frames with no gap cycle); if enable=0, it SHALL go to IDLE.
REQ-030 Deasserting enable mid-frame SHALL NOT truncate the frame.
REQ-031 In IDLE, fifo_rinc SHALL be 0; any pending output word SHALL still drain via tready.
REQ-032 underflow SHALL set when state=STREAM, x!=0, fifo_rempty=1 and the output slot is free; it SHALL be cleared only by rst.
REQ-033 Counters SHALL be CSIZE bits wide; comparisons SHALL use the latched sizes; h_active=1 SHALL give tuser and tlast on the same word.

Reset
REQ-034 While rst=1, outputs SHALL be: state=IDLE, m_axis_tvalid=0, tuser=0, tlast=0, tdata=0, fifo_rinc=0, frame_busy=0, underflow=0; counters and latched sizes SHALL be 0.
REQ-035 rst mid-frame SHALL abort immediately; the next frame SHALL start at x=0,y=0 with tuser; FIFO contents are not flushed by this block.

Structure
REQ-036 Package helai_video_pkg SHALL hold the state encoding (IDLE=0, STREAM=1) and the DSIZE/CSIZE defaults.
REQ-037 The output register SHALL be the single sub-module helai_axis_outreg (data+user+last, valid/ready); counters and FSM SHALL live in the top.

Verification
REQ-038 h=4, v=2, FIFO pre-filled with 8 words, tready=1: 8 beats; tuser on beat 0; tlast on beats 3 and 7; fifo_rinc high 8 cycles; back to IDLE.
REQ-039 Same stimulus, tready toggling 1/0 every cycle: data order is preserved, no word is dropped or duplicated, and the output is held stable while stalled.
REQ-040 FIFO empties after 2 of 4 pixels of a line: underflow=1, tvalid drops; after refill the line completes with tlast on pixel 3.
REQ-041 enable held high, two 2x2 frames: beat 4 carries tuser with no idle cycle in between, and frame_busy stays high.
REQ-042 rst for 1 cycle at pixel 5 of a 4x2 frame: all outputs are 0 next cycle; the following frame restarts with tuser.
REQ-043 h_active=0 with enable=1: the block stays in IDLE and fifo_rinc never asserts; h_active=1, v=3: 3 beats, each with tlast, and tuser only on the first.
